// File: rtl/aes_round_ctrl.sv
// AES encryption round sequencer: accepts a block, pulses the key load, steps NR rounds
// and holds the result until the consumer takes it. All outputs come straight from flops.
module aes_round_ctrl #(
    parameter int unsigned NR = 10,
    parameter int unsigned CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          abort,
    output logic          kld,
    output logic          st_ld,
    output logic          rnd_en,
    output logic          last_rnd,
    output logic [CW-1:0] rnd_cnt,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   blk_cnt
);

    localparam int unsigned BW = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] rnd_cnt_q, rnd_cnt_d;
    logic [BW-1:0] blk_cnt_q, blk_cnt_d;
    logic          in_ready_q, in_ready_d;
    logic          load_q, load_d;
    logic          rnd_en_q, rnd_en_d;
    logic          last_rnd_q, last_rnd_d;
    logic          out_valid_q, out_valid_d;

    // Next state plus next-cycle outputs, decoded from the next state so every output is a flop.
    always_comb begin
        state_d   = state_q;
        rnd_cnt_d = '0;
        blk_cnt_d = blk_cnt_q;

        case (state_q)
            IDLE: begin
                if (in_valid && !abort) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    state_d   = ROUND;
                    rnd_cnt_d = CW'(1);
                end
            end
            ROUND: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (rnd_cnt_q == CW'(NR)) begin
                    state_d = DONE;
                end else begin
                    rnd_cnt_d = rnd_cnt_q + CW'(1);
                end
            end
            DONE: begin
                // Abort takes priority over a simultaneous output handshake.
                if (abort) begin
                    state_d = IDLE;
                end else if (out_ready) begin
                    state_d   = IDLE;
                    blk_cnt_d = blk_cnt_q + BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        load_d      = (state_d == LOAD);
        rnd_en_d    = (state_d == ROUND);
        last_rnd_d  = (state_d == ROUND) && (rnd_cnt_d == CW'(NR));
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rnd_cnt_q   <= '0;
            blk_cnt_q   <= '0;
            in_ready_q  <= 1'b1;
            load_q      <= 1'b0;
            rnd_en_q    <= 1'b0;
            last_rnd_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rnd_cnt_q   <= rnd_cnt_d;
            blk_cnt_q   <= blk_cnt_d;
            in_ready_q  <= in_ready_d;
            load_q      <= load_d;
            rnd_en_q    <= rnd_en_d;
            last_rnd_q  <= last_rnd_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Key load and state load share the LOAD cycle, so one flop feeds both.
    assign in_ready  = in_ready_q;
    assign kld       = load_q;
    assign st_ld     = load_q;
    assign rnd_en    = rnd_en_q;
    assign last_rnd  = last_rnd_q;
    assign rnd_cnt   = rnd_cnt_q;
    assign out_valid = out_valid_q;
    assign blk_cnt   = blk_cnt_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: directed vector table, hand-written corner sequences and
// randomized traffic checked against a cycle-age reference model.
module tb_aes_round_ctrl;

    localparam int unsigned NR = 10;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          abort = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready, kld, st_ld, rnd_en, last_rnd, out_valid;
    logic [CW-1:0] rnd_cnt;
    logic [15:0]   blk_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: a block's age in cycles since acceptance determines every output.
    bit m_busy = 1'b0;
    int m_age  = 0;
    int m_blk  = 0;

    aes_round_ctrl #(.NR(NR), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .abort     (abort),
        .kld       (kld),
        .st_ld     (st_ld),
        .rnd_en    (rnd_en),
        .last_rnd  (last_rnd),
        .rnd_cnt   (rnd_cnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .blk_cnt   (blk_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          iv;
        logic          ab;
        logic          ordy;
        logic          e_rdy;
        logic          e_kld;
        logic          e_rnd;
        logic [CW-1:0] e_cnt;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_age  = 0;
        m_blk  = 0;
    endtask

    task automatic model_step(input logic iv, input logic ab, input logic ordy);
        if (!m_busy) begin
            if (iv && !ab) begin
                m_busy = 1'b1;
                m_age  = 1;
            end
        end else if (ab) begin
            m_busy = 1'b0;
        end else if (m_age >= int'(NR) + 2) begin
            if (ordy) begin
                m_busy = 1'b0;
                m_blk  = (m_blk + 1) % 65536;
            end
        end else begin
            m_age++;
        end
    endtask

    task automatic cmp_model(input string tag);
        bit in_rnd;
        in_rnd = m_busy && (m_age >= 2) && (m_age <= int'(NR) + 1);
        chk({tag, " in_ready"},  32'(in_ready),  32'(!m_busy));
        chk({tag, " kld"},       32'(kld),       32'(m_busy && m_age == 1));
        chk({tag, " st_ld"},     32'(st_ld),     32'(m_busy && m_age == 1));
        chk({tag, " rnd_en"},    32'(rnd_en),    32'(in_rnd));
        chk({tag, " rnd_cnt"},   32'(rnd_cnt),   in_rnd ? 32'(m_age - 1) : 32'd0);
        chk({tag, " last_rnd"},  32'(last_rnd),  32'(m_busy && m_age == int'(NR) + 1));
        chk({tag, " out_valid"}, 32'(out_valid), 32'(m_busy && m_age >= int'(NR) + 2));
        chk({tag, " blk_cnt"},   32'(blk_cnt),   32'(m_blk));
    endtask

    // One clock: drive inputs just after the falling edge, sample at the next falling edge.
    task automatic step(input logic iv, input logic ab, input logic ordy);
        in_valid  = iv;
        abort     = ab;
        out_ready = ordy;
        @(posedge clk);
        model_step(iv, ab, ordy);
        @(negedge clk);
        cmp_model("cyc");
    endtask

    task automatic run_to_done(input string tag);
        int n;
        n = 0;
        step(1'b1, 1'b0, 1'b0);
        chk({tag, " kld"}, 32'(kld), 32'd1);
        while (!out_valid && n < int'(NR) + 4) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
        end
        chk({tag, " done_latency"}, 32'(n), 32'(NR + 1));
    endtask

    initial begin
        vec_t vecs[6];
        int   n, t, n_rnd, n_last, n_kld, cnt_at_last;

        vecs[0] = '{iv: 1'b1, ab: 1'b1, ordy: 1'b0, e_rdy: 1'b1, e_kld: 1'b0, e_rnd: 1'b0, e_cnt: 4'd0};
        vecs[1] = '{iv: 1'b1, ab: 1'b0, ordy: 1'b0, e_rdy: 1'b0, e_kld: 1'b1, e_rnd: 1'b0, e_cnt: 4'd0};
        vecs[2] = '{iv: 1'b1, ab: 1'b0, ordy: 1'b0, e_rdy: 1'b0, e_kld: 1'b0, e_rnd: 1'b1, e_cnt: 4'd1};
        vecs[3] = '{iv: 1'b1, ab: 1'b0, ordy: 1'b0, e_rdy: 1'b0, e_kld: 1'b0, e_rnd: 1'b1, e_cnt: 4'd2};
        vecs[4] = '{iv: 1'b0, ab: 1'b1, ordy: 1'b0, e_rdy: 1'b1, e_kld: 1'b0, e_rnd: 1'b0, e_cnt: 4'd0};
        vecs[5] = '{iv: 1'b0, ab: 1'b0, ordy: 1'b0, e_rdy: 1'b1, e_kld: 1'b0, e_rnd: 1'b0, e_cnt: 4'd0};

        // Reset state
        model_reset();
        repeat (2) @(negedge clk);
        cmp_model("reset");
        rst = 1'b1;

        // Directed vector table: abort blocks acceptance in IDLE, busy ignores in_valid, abort mid-round
        for (int i = 0; i < 6; i++) begin
            in_valid  = vecs[i].iv;
            abort     = vecs[i].ab;
            out_ready = vecs[i].ordy;
            @(posedge clk);
            model_step(vecs[i].iv, vecs[i].ab, vecs[i].ordy);
            @(negedge clk);
            chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
            chk($sformatf("vec%0d kld", i),      32'(kld),      32'(vecs[i].e_kld));
            chk($sformatf("vec%0d rnd_en", i),   32'(rnd_en),   32'(vecs[i].e_rnd));
            chk($sformatf("vec%0d rnd_cnt", i),  32'(rnd_cnt),  32'(vecs[i].e_cnt));
        end

        // Single block timing with in_valid held high while busy
        step(1'b1, 1'b0, 1'b1);
        chk("t1 kld", 32'(kld), 32'd1);
        chk("t1 st_ld", 32'(st_ld), 32'd1);
        t = 1; n_rnd = 0; n_last = 0; n_kld = 0; cnt_at_last = 0;
        while (!out_valid && t < 20) begin
            step(1'b1, 1'b0, 1'b1);
            t++;
            if (rnd_en) n_rnd++;
            if (kld) n_kld++;
            if (last_rnd) begin
                n_last++;
                cnt_at_last = int'(rnd_cnt);
            end
        end
        chk("t1 out_valid_latency", 32'(t), 32'(NR + 2));
        chk("t1 rnd_en_cycles", 32'(n_rnd), 32'(NR));
        chk("t1 last_rnd_cycles", 32'(n_last), 32'd1);
        chk("t1 last_rnd_cnt", 32'(cnt_at_last), 32'(NR));
        chk("t1 extra_kld", 32'(n_kld), 32'd0);
        step(1'b0, 1'b0, 1'b1);
        chk("t1 blk_cnt", 32'(blk_cnt), 32'd1);
        chk("t1 in_ready", 32'(in_ready), 32'd1);

        // Backpressure holds the result
        run_to_done("t2");
        repeat (5) step(1'b0, 1'b0, 1'b0);
        chk("t2 out_valid_held", 32'(out_valid), 32'd1);
        chk("t2 in_ready_held", 32'(in_ready), 32'd0);
        chk("t2 blk_cnt_held", 32'(blk_cnt), 32'd1);
        step(1'b0, 1'b0, 1'b1);
        chk("t2 idle_after_hs", 32'(in_ready), 32'd1);
        chk("t2 blk_cnt", 32'(blk_cnt), 32'd2);

        // Abort at round 4, then a fresh full block
        step(1'b1, 1'b0, 1'b0);
        n = 0;
        while (rnd_cnt != CW'(4) && n < 20) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
        end
        chk("t3 reached_rnd4", 32'(rnd_cnt), 32'd4);
        step(1'b0, 1'b1, 1'b0);
        chk("t3 abort_in_ready", 32'(in_ready), 32'd1);
        chk("t3 abort_rnd_en", 32'(rnd_en), 32'd0);
        chk("t3 abort_out_valid", 32'(out_valid), 32'd0);
        run_to_done("t3");
        step(1'b0, 1'b0, 1'b1);
        chk("t3 blk_cnt", 32'(blk_cnt), 32'd3);

        // Abort wins over out_ready in DONE; abort with in_valid in IDLE does nothing
        run_to_done("t4");
        step(1'b0, 1'b1, 1'b1);
        chk("t4 out_valid", 32'(out_valid), 32'd0);
        chk("t4 in_ready", 32'(in_ready), 32'd1);
        chk("t4 blk_cnt", 32'(blk_cnt), 32'd3);
        step(1'b1, 1'b1, 1'b0);
        chk("t4 no_load", 32'(kld), 32'd0);
        chk("t4 still_idle", 32'(in_ready), 32'd1);

        // Asynchronous reset at round 7, away from any clock edge
        step(1'b1, 1'b0, 1'b0);
        n = 0;
        while (rnd_cnt != CW'(7) && n < 20) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
        end
        chk("t5 reached_rnd7", 32'(rnd_cnt), 32'd7);
        #2 rst = 1'b0;
        #1;
        model_reset();
        cmp_model("t5 async_rst");
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        chk("t5 no_out_valid", 32'(out_valid), 32'd0);

        // Block counter wraps from 16'hFFFF to 0
        force dut.blk_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.blk_cnt_q;
        m_blk = 65535;
        step(1'b0, 1'b0, 1'b0);
        chk("t5 preset", 32'(blk_cnt), 32'h0000_FFFF);
        run_to_done("t5");
        step(1'b0, 1'b0, 1'b1);
        chk("t5 blk_cnt_wrap", 32'(blk_cnt), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(1'(($urandom % 3) != 0), 1'(($urandom % 25) == 0), 1'(($urandom % 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
